// File: rtl/dti_pr_reset_seq.sv
// dti_pr_reset_seq: drains upstream packets, pulses bridge partial reset until idle/timeout, then acks requester
module dti_pr_reset_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pr_req,
  output logic             pr_ack,
  output logic             pr_err,
  input  logic [CNT_W-1:0] timeout_cfg,
  input  logic             req_tvalid,
  input  logic             req_tready,
  input  logic             req_tlast,
  input  logic             idle,
  output logic             partial_reset,
  output logic             hold_start,
  output logic             busy,
  output logic [CNT_W-1:0] flush_cycles
);
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_e;
  state_e           state_q, state_d;
  logic             in_pkt_q, in_pkt_d, pr_err_q, pr_err_d, hs, hit_to;
  logic [CNT_W-1:0] cnt_q, cnt_d, fc_q, fc_d, cnt_inc;
  assign hs       = req_tvalid && req_tready;
  assign in_pkt_d = hs ? !req_tlast : in_pkt_q;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign hit_to   = (timeout_cfg != '0) && (cnt_q == timeout_cfg - 1'b1);
  // state register, packet tracker, flush counter and sticky results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      in_pkt_q <= 1'b0;
      pr_err_q <= 1'b0;
      cnt_q    <= '0;
      fc_q     <= '0;
    end else begin
      state_q  <= state_d;
      in_pkt_q <= in_pkt_d;
      pr_err_q <= pr_err_d;
      cnt_q    <= cnt_d;
      fc_q     <= fc_d;
    end
  end
  // sequencing: idle has priority over timeout; pr_err cleared only when a new sequence starts
  always_comb begin
    state_d  = state_q;
    pr_err_d = pr_err_q;
    cnt_d    = cnt_q;
    fc_d     = fc_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pr_req) begin
          state_d  = DRAIN;
          pr_err_d = 1'b0;
        end
      end
      DRAIN: state_d = (!in_pkt_q && !hs) ? FLUSH : DRAIN;
      FLUSH: begin
        cnt_d = cnt_inc;
        if (idle || hit_to) begin
          state_d  = DONE;
          pr_err_d = !idle;
          fc_d     = cnt_inc;
        end
      end
      DONE: state_d = pr_req ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign partial_reset = (state_q == FLUSH);
  assign hold_start    = (state_q != IDLE);
  assign busy          = (state_q != IDLE);
  assign pr_ack        = (state_q == DONE);
  assign pr_err        = pr_err_q;
  assign flush_cycles  = fc_q;
endmodule
